// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter and one-cycle sequencer for a
// single-port memory with a shared tri-state data bus.
module mem_arbiter #(
  parameter int data_width = 8,
  parameter int addr_width = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [addr_width-1:0] addr0,
  input  logic [addr_width-1:0] addr1,
  input  logic [data_width-1:0] wdata0,
  input  logic [data_width-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [data_width-1:0] rdata,
  output logic                  busy,
  output logic [addr_width-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  inout  wire  [data_width-1:0] mem_data
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t                r_state;
  logic                  r_last;
  logic                  r_port;
  logic                  r_rd;
  logic                  r_wr;
  logic                  r_ack0;
  logic                  r_ack1;
  logic [addr_width-1:0] r_addr;
  logic [data_width-1:0] r_wdata;
  logic [data_width-1:0] r_rdata;
  logic                  w_el0;
  logic                  w_el1;
  logic                  w_gnt;
  logic                  w_we;
  // a port is masked in its own ack cycle so a held request cannot be granted twice
  assign w_el0 = req0 & ~r_ack0;
  assign w_el1 = req1 & ~r_ack1;
  assign w_gnt = (w_el0 & w_el1) ? ~r_last : w_el1;
  assign w_we  = w_gnt ? we1 : we0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_port  <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else if (r_state == IDLE) begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      if (w_el0 | w_el1) begin
        r_state <= ACCESS;
        r_last  <= w_gnt;
        r_port  <= w_gnt;
        r_addr  <= w_gnt ? addr1 : addr0;
        r_wdata <= w_gnt ? wdata1 : wdata0;
        r_rd    <= ~w_we;
        r_wr    <= w_we;
      end
    end else begin
      r_state <= IDLE;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_ack0  <= ~r_port;
      r_ack1  <= r_port;
      if (r_rd) r_rdata <= mem_data;
    end
  end
  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign rdata    = r_rdata;
  assign busy     = (r_state == ACCESS);
  assign mem_addr = r_addr;
  assign mem_rd   = r_rd;
  assign mem_wr   = r_wr;
  assign mem_data = r_wr ? r_wdata : 'z;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed stimulus for mem_arbiter with a memory
// model on the bus and a transaction-level reference model.
module tb_mem_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req [2];
  logic       we [2];
  logic [4:0] addr [2];
  logic [7:0] wdata [2];
  logic       ack [2];
  logic [7:0] rdata;
  logic       busy;
  logic [4:0] mem_addr;
  logic       mem_rd;
  logic       mem_wr;
  wire  [7:0] mem_data;
  logic [7:0] mem [32];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .ack0(ack[0]), .ack1(ack[1]), .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // memory block: no reset, write commits at the edge where mem_wr is high
  assign mem_data = mem_rd ? mem[mem_addr] : 8'hzz;
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 37 + 11);
    forever @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // reference model: one in-flight transaction record plus a shadow memory
  typedef struct {bit port; bit we; logic [4:0] addr; logic [7:0] data;} txn_t;
  txn_t       cur;
  bit         m_busy = 0;
  bit         m_last = 1;
  bit         e_ack [2] = '{0, 0};
  logic [7:0] e_rdata = 0;
  logic [4:0] e_addr = 0;
  logic [7:0] ref_mem [32];
  initial for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i * 37 + 11);

  always @(negedge clk) begin
    bit el0, el1, p;
    check("ack0", ack[0], e_ack[0]);
    check("ack1", ack[1], e_ack[1]);
    check("busy", busy, m_busy);
    check("mem_rd", mem_rd, m_busy && !cur.we);
    check("mem_wr", mem_wr, m_busy && cur.we);
    check("mem_addr", mem_addr, e_addr);
    check("rdata", rdata, e_rdata);
    if (m_busy && cur.we) check("mem_data", mem_data, cur.data);
    if (!rst_n) begin
      if (m_busy && cur.we) ref_mem[cur.addr] = cur.data;
      m_busy = 0; m_last = 1; e_ack = '{0, 0}; e_rdata = 0; e_addr = 0;
    end else if (m_busy) begin
      if (cur.we) ref_mem[cur.addr] = cur.data;
      else e_rdata = ref_mem[cur.addr];
      e_ack[cur.port] = 1; e_ack[!cur.port] = 0;
      m_busy = 0;
    end else begin
      el0 = req[0] && !e_ack[0];
      el1 = req[1] && !e_ack[1];
      e_ack = '{0, 0};
      if (el0 || el1) begin
        p = (el0 && el1) ? !m_last : el1;
        m_last = p;
        cur = '{p, we[p], addr[p], wdata[p]};
        e_addr = addr[p];
        m_busy = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic wait_ack(input int p, input bit hold);
    for (int k = 0; k < 20; k++) begin
      step();
      if (ack[p]) begin
        if (!hold) req[p] = 0;
        return;
      end
    end
    check($sformatf("ack%0d_timeout", p), 0, 1);
    req[p] = 0;
  endtask

  task automatic access(input int p, input bit w, input logic [4:0] a, input logic [7:0] d);
    req[p] = 1; we[p] = w; addr[p] = a; wdata[p] = d;
    wait_ack(p, 0);
  endtask

  int  wt [2] = '{0, 0};
  bit  dropped [2] = '{0, 0};
  task automatic drive_cycle(input bit fair);
    step();
    for (int p = 0; p < 2; p++) begin
      if (req[p] && ack[p]) begin
        if (fair) check($sformatf("wait%0d", p), wt[p] <= 4, 1);
        wt[p] = 0;
        if (fair || $urandom_range(3) != 0) begin
          req[p] = 0; dropped[p] = 1;
        end else begin
          we[p] = 1'($urandom); addr[p] = 5'($urandom); wdata[p] = 8'($urandom);
        end
      end else if (req[p]) wt[p]++;
      else if (fair ? dropped[p] : $urandom_range(1) == 1) begin
        req[p] = 1; dropped[p] = 0; wt[p] = 0;
        we[p] = 1'($urandom); addr[p] = 5'($urandom); wdata[p] = 8'($urandom);
      end
    end
  endtask

  initial begin
    int t0, t1, cnt;
    rst_n = 0;
    for (int p = 0; p < 2; p++) begin
      req[p] = 0; we[p] = 0; addr[p] = 0; wdata[p] = 0;
    end
    req[0] = 1;
    step(); step();
    rst_n = 1;
    wait_ack(0, 0);
    step();
    access(0, 1, 5'h03, 8'hA5);
    access(0, 0, 5'h03, 8'h00);
    check("rd_a5", rdata, 8'hA5);
    rst_n = 0; step(); rst_n = 1;
    t0 = -1; t1 = -1;
    req[0] = 1; we[0] = 0; addr[0] = 5'h03;
    req[1] = 1; we[1] = 0; addr[1] = 5'h07;
    for (int k = 0; k < 20 && (t0 < 0 || t1 < 0); k++) begin
      step();
      if (ack[0] && t0 < 0) begin t0 = cyc; req[0] = 0; end
      if (ack[1] && t1 < 0) begin t1 = cyc; req[1] = 0; end
    end
    check("tie_p0_first", t0 >= 0 && t1 > t0, 1);
    check("tie_gap", t1 - t0, 2);
    step();
    for (int k = 0; k < 200; k++) drive_cycle(1);
    req[0] = 0; req[1] = 0;
    repeat (4) step();
    req[1] = 1; we[1] = 0; addr[1] = 5'h0A;
    wait_ack(1, 1);
    step();
    req[1] = 0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin step(); cnt += int'(ack[1]); end
    check("dup_guard", cnt, 0);
    req[1] = 1;
    wait_ack(1, 1);
    step();
    wait_ack(1, 0);
    req[0] = 1; we[0] = 1; addr[0] = 5'h1F; wdata[0] = 8'h3C;
    step();
    check("busy_mid_write", busy, 1);
    rst_n = 0; req[0] = 0;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin step(); cnt += int'(ack[0]) + int'(ack[1]); end
    rst_n = 1;
    check("rst_no_ack", cnt, 0);
    access(0, 0, 5'h1F, 8'h00);
    check("rd_3c", rdata, 8'h3C);
    step();
    for (int k = 0; k < 400; k++) drive_cycle(0);
    req[0] = 0; req[1] = 0;
    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single-port, tri-state-bus `memory` block. It shares the memory between an instruction-fetch requester (port 0) and a load/store requester (port 1) using round-robin arbitration. It drives `addr`, `rd`, `wr` and the bidirectional `data` bus, and returns read data with a one-cycle acknowledge pulse. It sits between the CPU control unit and `memory`.

## Interface
- `data_width`, default 8: width of the memory word and all data ports.
- `addr_width`, default 5: width of the memory address and all address ports.

- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req0`, `req1`  in  1 each: access request, port 0 (fetch) and port 1 (load/store). Held high with stable `weN`/`addrN`/`wdataN` until `ackN`.
- `we0`, `we1`  in  1 each: 1 = write, 0 = read.
- `addr0`, `addr1`  in  `addr_width` each: access address.
- `wdata0`, `wdata1`  in  `data_width` each: write data.
- `ack0`, `ack1`  out  1 each: one-cycle completion pulse per port.
- `rdata`  out  `data_width`: read result; valid while the matching `ackN` is 1 after a read.
- `busy`  out  1: high while in ACCESS.
- `mem_addr`  out  `addr_width`: to memory `addr`.
- `mem_rd`  out  1: to memory `rd`.
- `mem_wr`  out  1: to memory `wr`.
- `mem_data`  inout  `data_width`: to memory `data`. Driven with latched write data only while `mem_wr` is 1; hi-Z otherwise.

## Operation
- States: IDLE and ACCESS. `state`, `mem_addr`, `mem_rd`, `mem_wr`, `ackN` and `rdata` are all registered.
- **IDLE transition:** if any eligible request is present, latch the winner's `addr`, `we` and `wdata`, then go to ACCESS. Set `mem_rd = ~we` or `mem_wr = we`. Otherwise stay in IDLE.
- **Eligibility:** `reqN` is ignored in any cycle where `ackN` = 1. The requester drops `req` on seeing `ack`; this masking prevents a duplicate grant.
- **Round-robin:** a 1-bit `last` register records the most recently granted port.
  - Both ports eligible: grant `~last`.
  - One port eligible: grant it.
  - `last` updates on every grant.
- **ACCESS:** lasts exactly one cycle, with `mem_rd` or `mem_wr` high.
  - At the closing edge, a read loads `rdata` from `mem_data`. A write commits in memory at that same edge.
  - At that edge: clear `mem_rd`/`mem_wr`, pulse `ackN` for the granted port, return to IDLE.
  - On a write, `rdata` holds its previous value.
- **Bus ownership:** the arbiter and the memory never drive `mem_data` in the same cycle, because `mem_rd` and `mem_wr` are mutually exclusive. No turnaround cycle is needed.
- **Reset values:**
  - state IDLE; `mem_addr` = 0; `mem_rd` = 0; `mem_wr` = 0.
  - `ack0` = `ack1` = 0; `rdata` = 0; `busy` = 0.
  - `last` = 1, so port 0 wins the first tie.
  - `mem_data` hi-Z.
- **Reset mid-ACCESS:** the memory has no reset, so a write whose `mem_wr` is high at the reset edge still commits. No `ack` is generated. The requester must reissue.

## Timing
- **Latency:** `req` sampled high at edge E0 gives ACCESS in the cycle after E0. `ack` and `rdata` are valid in the cycle after E1.
- **Throughput:** one access per 2 cycles. The IDLE/ack cycle can grant the other port, so alternating ports sustain 50% memory utilisation.
- **Handshake:** `addrN`/`weN`/`wdataN` must be stable only at the grant edge; they are latched there. Changing them after the grant does not affect the access.
- **Requests during ACCESS:** new requests are not sampled; they are evaluated in the following IDLE cycle.

## Test plan
1. **Reset:** hold `rst_n` = 0 for 2 cycles with `req0` = 1. Required:
   - all outputs at their reset values;
   - `mem_data` = Z;
   - no grant until the first edge after release.
2. **Port 0 write then read:** write 8'hA5 to addr 5'h03 via port 0, then read 5'h03. Required:
   - `mem_wr` high for exactly 1 cycle with `mem_data` = A5;
   - `ack0` pulses twice;
   - `rdata` = A5 during the second `ack0`.
3. **Tie after reset:** `req0` = `req1` = 1 simultaneously, both reads, held until ack. Required:
   - port 0 is granted first, port 1 is granted in the `ack0` cycle;
   - `ack1` arrives 2 cycles after `ack0`.
4. **Fairness:** both ports request continuously, re-raising `req` one cycle after each ack. Required:
   - grants alternate 0,1,0,1;
   - neither port waits more than 4 cycles from `req` to `ack`.
5. **Duplicate-grant guard:** port 1 holds `req1` high through the `ack1` cycle, `req0` low. Required:
   - no second port-1 grant in the `ack1` cycle;
   - grant only if `req1` is still high the cycle after.
6. **Reset mid-write:** assert `rst_n` = 0 during the ACCESS cycle of a write of 8'h3C to 5'h1F. Required:
   - no `ack`;
   - after reset, a port-0 read of 5'h1F returns 3C.
